// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
// Also holds the two's-complement magnitude helper used when latching operands.
package div_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int DIV_ITERS = 8;
  localparam logic [7:0] DIV0_QUOT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Unsigned magnitude of a signed byte; -128 maps to 8'h80.
  function automatic logic [7:0] mag(input logic [7:0] x);
    mag = x[7] ? (~x + 8'd1) : x;
  endfunction

endpackage

// File: rtl/ripple_adder.sv
// 8-bit ripple-carry adder shared by the multiplier and divider datapaths.
// Purely combinational; s = a + b + cin with carry out.
module ripple_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  logic [8:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[8];

endmodule

// File: rtl/divider.sv
// Signed 8-bit restoring divider, one quotient bit per clock; done 10 edges after accept (2 for /0).
// start is ignored while busy or in DONE; no queueing, so the requester must retry.
module divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  state_t           state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] d_reg;
  logic             sign_q;
  logic             sign_r;
  logic             ovf_case;

  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] diff;
  logic             no_borrow;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Shift the next dividend bit into the partial remainder, then trial-subtract D.
  assign trial = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};

  ripple_adder u_trial_sub (
    .a    (trial),
    .b    (~d_reg),
    .cin  (1'b1),
    .s    (diff),
    .cout (no_borrow)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      d_reg       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      ovf_case    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sign_q      <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r      <= dividend[WIDTH-1];
            q_reg       <= mag(dividend);
            d_reg       <= mag(divisor);
            cnt         <= '0;
            overflow    <= 1'b0;
            ovf_case    <= (dividend == MOST_NEG) && (divisor == '1);
            div_by_zero <= (divisor == '0);
            if (divisor == '0) begin
              // Park the raw dividend in R so DONE can return it as the remainder.
              r_reg <= dividend;
              state <= DONE;
            end else begin
              r_reg <= '0;
              busy  <= 1'b1;
              state <= ITER;
            end
          end
        end

        ITER: begin
          q_reg <= {q_reg[WIDTH-2:0], no_borrow};
          r_reg <= no_borrow ? diff : trial;
          cnt   <= cnt + 4'd1;
          if (cnt == 4'(DIV_ITERS - 1)) begin
            state <= FIX;
          end
        end

        FIX: begin
          quotient  <= sign_q ? (~q_reg + 1'b1) : q_reg;
          remainder <= sign_r ? (~r_reg + 1'b1) : r_reg;
          overflow  <= ovf_case;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
        end

        DONE: begin
          // Entered with done low only on the divide-by-zero path.
          if (done) begin
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            quotient  <= DIV0_QUOT;
            remainder <= r_reg;
            done      <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
